peripheral_system_led_driver: RTL and testbench
===============================================

PERIPHERAL_SYSTEM_LED_DRIVER -- requirements
Module: peripheral_system_led_driver

Interface
REQ-001 SHALL have port: clk  input  1  single system clock; all logic on its rising edge.
REQ-002 SHALL have port: reset_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: address  input  2  Avalon-MM slave word address.
REQ-004 SHALL have port: chipselect  input  1  slave select.
REQ-005 SHALL have port: write_n  input  1  active-low write strobe.
REQ-006 SHALL have port: writedata  input  32  write data.
REQ-007 SHALL have port: readdata  output  32  read data; combinational on address.
REQ-008 SHALL have port: led_in  input  8  LED pattern from the LED PIO out_port.
REQ-009 SHALL have port: led_out  output  8  registered drive to the board LED pins.

Function
REQ-010 A write SHALL occur on a clk edge with chipselect=1 and write_n=0, with no wait states.
REQ-011 Register map: addr0 CTRL[2:0] = {invert, blink_en, enable}; addr1 PRESCALE[15:0]; addr2 DUTY[7:0]; addr3 BLINK[7:0].
REQ-012 Writes SHALL take the low-order writedata bits of each register width; upper bits are ignored.
REQ-013 readdata SHALL return the addressed register, zero-extended to 32 bits, independent of chipselect.
REQ-014 led_in SHALL be registered once into led_q on every clk edge.
REQ-015 Prescaler presc_cnt[15:0]: tick SHALL be 1 for one cycle when presc_cnt==PRESCALE, and presc_cnt then wraps to 0; otherwise presc_cnt increments.
REQ-016 PRESCALE=0 SHALL produce tick on every cycle.
REQ-017 PWM counter pwm_cnt[7:0] SHALL increment on tick and wrap 255->0.
REQ-018 frame_end SHALL be tick AND pwm_cnt==255.
REQ-019 pwm_on SHALL equal (pwm_cnt < DUTY): DUTY=0 is always off; DUTY=0xFF is on 255 of 256 counts.
REQ-020 Blink counter blink_cnt[7:0] SHALL increment on frame_end.
REQ-021 When frame_end occurs with blink_cnt==BLINK, blink_cnt SHALL clear and blink_phase SHALL toggle, giving a half-period of (BLINK+1) frames.
REQ-022 Next led_out SHALL be, per bit: (enable & led_q[i] & pwm_on & (~blink_en | blink_phase)) XOR invert.
REQ-023 Latency: a led_in change SHALL appear on led_out 2 clk edges later when the gating terms are 1.
REQ-024 While enable=0: presc_cnt, pwm_cnt and blink_cnt SHALL be held at 0, blink_phase held at 1, and led_out = {8{invert}}.
REQ-025 A write to PRESCALE SHALL clear presc_cnt on the same edge; pwm_cnt is unaffected.
REQ-026 A write to BLINK SHALL clear blink_cnt on the same edge; blink_phase is unaffected.
REQ-027 A write to DUTY SHALL take effect on the pwm_on compare in the cycle after the write; counters are unaffected.
REQ-028 If a register-clearing write coincides with a tick or frame_end, the clear SHALL win and the counter SHALL be 0 after the edge.
REQ-029 Writing PRESCALE below the current presc_cnt SHALL not stall the prescaler, because REQ-025 clears the count.

Reset
REQ-030 On reset_n=0, asynchronously: CTRL=0, PRESCALE=0x0031, DUTY=0xFF, BLINK=0x00.
REQ-031 On reset_n=0, asynchronously: led_q=0, presc_cnt=0, pwm_cnt=0, blink_cnt=0, blink_phase=1, led_out=0x00.
REQ-032 Reset asserted mid-frame SHALL abort immediately to the REQ-030/031 values; operation resumes from count 0 after deassertion.

Verification
REQ-033 Reset, then read addr0..3 -> 0x0, 0x31, 0xFF, 0x0; led_out=0x00.
REQ-034 CTRL=0x1, PRESCALE=0, DUTY=0x40, led_in=0xA5 -> led_out=0xA5 for 64 consecutive clocks and 0x00 for 192 clocks, repeating every 256 clocks.
REQ-035 CTRL=0x3, PRESCALE=0, DUTY=0xFF, BLINK=1, led_in=0xFF -> blink_phase toggles every 512 clocks; led_out is 0x00 throughout each off half-period.
REQ-036 CTRL=0x5 (invert), PRESCALE=0, DUTY=0, led_in=0x0F -> led_out=0xFF constant; then write CTRL=0x4 -> led_out=0xFF while counters read 0.
REQ-037 PRESCALE=3 -> tick every 4 clocks, pwm period 1024 clocks; write PRESCALE=3 in the same cycle presc_cnt==3 -> no tick, presc_cnt=0 after the edge.
REQ-038 Assert reset_n for 1 cycle mid-PWM-period with CTRL=0x1 -> led_out=0x00 immediately; CTRL reads 0 after release.

Source files
------------

// File: rtl/peripheral_system_led_driver.sv
// ============================================================================
//  peripheral_system_led_driver -- Avalon-MM LED driver: PWM, blink, invert
//  Revision: 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module peripheral_system_led_driver (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [7:0]  led_in,
  output logic [7:0]  led_out
);

  localparam logic [1:0]  ADDR_CTRL     = 2'd0;
  localparam logic [1:0]  ADDR_PRESCALE = 2'd1;
  localparam logic [1:0]  ADDR_DUTY     = 2'd2;
  localparam logic [1:0]  ADDR_BLINK    = 2'd3;

  localparam logic [2:0]  CTRL_RST      = 3'd0;
  localparam logic [15:0] PRESCALE_RST  = 16'h0031;
  localparam logic [7:0]  DUTY_RST      = 8'hFF;
  localparam logic [7:0]  BLINK_RST     = 8'h00;

  logic [2:0]  ctrl_q,        ctrl_d;
  logic [15:0] prescale_q,    prescale_d;
  logic [7:0]  duty_q,        duty_d;
  logic [7:0]  blink_q,       blink_d;
  logic [7:0]  led_q,         led_d;
  logic [15:0] presc_cnt_q,   presc_cnt_d;
  logic [7:0]  pwm_cnt_q,     pwm_cnt_d;
  logic [7:0]  blink_cnt_q,   blink_cnt_d;
  logic        blink_phase_q, blink_phase_d;
  logic [7:0]  led_out_q,     led_out_d;

  logic wr_en;
  logic wr_presc;
  logic wr_blink;
  logic enable;
  logic blink_en;
  logic invert;
  logic tick;
  logic frame_end;
  logic pwm_on;
  logic gate;

  // Only the low 16 bits of writedata ever reach a register.
  logic unused_wdata;
  assign unused_wdata = ^writedata[31:16];

  assign wr_en    = chipselect & ~write_n;
  assign wr_presc = wr_en && (address == ADDR_PRESCALE);
  assign wr_blink = wr_en && (address == ADDR_BLINK);

  assign enable   = ctrl_q[0];
  assign blink_en = ctrl_q[1];
  assign invert   = ctrl_q[2];

  always_comb begin
    ctrl_d     = ctrl_q;
    prescale_d = prescale_q;
    duty_d     = duty_q;
    blink_d    = blink_q;
    if (wr_en) begin
      case (address)
        ADDR_CTRL:     ctrl_d     = writedata[2:0];
        ADDR_PRESCALE: prescale_d = writedata[15:0];
        ADDR_DUTY:     duty_d     = writedata[7:0];
        ADDR_BLINK:    blink_d    = writedata[7:0];
        default:       ctrl_d     = ctrl_q;
      endcase
    end
  end

  always_comb begin
    readdata = 32'd0;
    case (address)
      ADDR_CTRL:     readdata = {29'd0, ctrl_q};
      ADDR_PRESCALE: readdata = {16'd0, prescale_q};
      ADDR_DUTY:     readdata = {24'd0, duty_q};
      ADDR_BLINK:    readdata = {24'd0, blink_q};
      default:       readdata = 32'd0;
    endcase
  end

  // A PRESCALE write restarts the count, so it also suppresses the tick it collides with.
  assign tick      = enable && (presc_cnt_q == prescale_q) && !wr_presc;
  assign frame_end = tick && (pwm_cnt_q == 8'hFF);
  assign pwm_on    = (pwm_cnt_q < duty_q);
  assign gate      = enable & pwm_on & (~blink_en | blink_phase_q);

  always_comb begin
    led_d         = led_in;
    presc_cnt_d   = presc_cnt_q + 16'd1;
    pwm_cnt_d     = pwm_cnt_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    led_out_d     = (led_q & {8{gate}}) ^ {8{invert}};

    if (!enable) begin
      presc_cnt_d   = 16'd0;
      pwm_cnt_d     = 8'd0;
      blink_cnt_d   = 8'd0;
      blink_phase_d = 1'b1;
    end else begin
      if (tick || wr_presc) begin
        presc_cnt_d = 16'd0;
      end
      if (tick) begin
        pwm_cnt_d = pwm_cnt_q + 8'd1;
      end
      if (frame_end) begin
        if (blink_cnt_q == blink_q) begin
          blink_cnt_d   = 8'd0;
          blink_phase_d = ~blink_phase_q;
        end else begin
          blink_cnt_d = blink_cnt_q + 8'd1;
        end
      end
      if (wr_blink) begin
        blink_cnt_d = 8'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q        <= CTRL_RST;
      prescale_q    <= PRESCALE_RST;
      duty_q        <= DUTY_RST;
      blink_q       <= BLINK_RST;
      led_q         <= 8'd0;
      presc_cnt_q   <= 16'd0;
      pwm_cnt_q     <= 8'd0;
      blink_cnt_q   <= 8'd0;
      blink_phase_q <= 1'b1;
      led_out_q     <= 8'd0;
    end else begin
      ctrl_q        <= ctrl_d;
      prescale_q    <= prescale_d;
      duty_q        <= duty_d;
      blink_q       <= blink_d;
      led_q         <= led_d;
      presc_cnt_q   <= presc_cnt_d;
      pwm_cnt_q     <= pwm_cnt_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      led_out_q     <= led_out_d;
    end
  end

  assign led_out = led_out_q;

endmodule

`default_nettype wire

// File: tb/tb_peripheral_system_led_driver.sv
// Directed bench for peripheral_system_led_driver: register table plus PWM/blink/invert/reset sequences.
`timescale 1ns/1ps
`default_nettype none

module tb_peripheral_system_led_driver;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  led_in;
  logic [7:0]  led_out;

  int n_cmp  = 0;
  int n_fail = 0;
  int bad;
  logic [7:0] expv;

  typedef struct {
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [6];

  always #5 clk = ~clk;

  peripheral_system_led_driver dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .led_in     (led_in),
    .led_out    (led_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 2'd0;
    writedata  = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Returns #1 after the capturing edge, i.e. inside the cycle following the write.
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic read_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
    address = a;
    #1;
    check(name, readdata, exp);
  endtask

  initial begin
    vecs[0] = '{2'd1, 32'hDEAD0007, 32'h0000_0007};
    vecs[1] = '{2'd2, 32'hFFFFFF80, 32'h0000_0080};
    vecs[2] = '{2'd3, 32'h12345603, 32'h0000_0003};
    vecs[3] = '{2'd0, 32'hFFFFFFF6, 32'h0000_0006};
    vecs[4] = '{2'd1, 32'h0001FFFF, 32'h0000_FFFF};
    vecs[5] = '{2'd2, 32'h00000000, 32'h0000_0000};

    led_in = 8'h00;
    do_reset();

    // Reset values
    read_chk("rst_ctrl",     2'd0, 32'h0);
    read_chk("rst_prescale", 2'd1, 32'h31);
    read_chk("rst_duty",     2'd2, 32'hFF);
    read_chk("rst_blink",    2'd3, 32'h0);
    check("rst_led_out", {24'd0, led_out}, 32'h0);

    // Register write/readback with upper bits discarded
    for (int i = 0; i < 6; i++) begin
      bus_write(vecs[i].addr, vecs[i].wdata);
      read_chk($sformatf("reg_vec%0d", i), vecs[i].addr, vecs[i].exp_rd);
    end

    // PWM 64/256 duty
    do_reset();
    led_in = 8'hA5;
    bus_write(2'd1, 32'd0);
    bus_write(2'd2, 32'h40);
    bus_write(2'd0, 32'h1);
    bad = 0;
    for (int k = 1; k <= 512; k++) begin
      @(posedge clk); #1;
      expv = (((k - 1) % 256) < 64) ? 8'hA5 : 8'h00;
      if (led_out !== expv) bad++;
    end
    check("pwm_duty40_bad_cycles", bad, 0);

    // Blink with BLINK=1: half-period 512 clocks, one off count per frame
    do_reset();
    led_in = 8'hFF;
    bus_write(2'd1, 32'd0);
    bus_write(2'd3, 32'd1);
    bus_write(2'd0, 32'h3);
    bad = 0;
    for (int k = 0; k < 1600; k++) begin
      @(posedge clk); #1;
      expv = (((k % 256) != 255) && (((k / 512) % 2) == 0)) ? 8'hFF : 8'h00;
      if (led_out !== expv) bad++;
    end
    check("blink_bad_cycles", bad, 0);

    // Invert with DUTY=0, then disable with invert still set
    do_reset();
    led_in = 8'h0F;
    bus_write(2'd1, 32'd0);
    bus_write(2'd2, 32'd0);
    bus_write(2'd0, 32'h5);
    bad = 0;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk); #1;
      if (led_out !== 8'hFF) bad++;
    end
    check("invert_duty0_bad_cycles", bad, 0);
    bus_write(2'd0, 32'h4);
    repeat (3) @(posedge clk);
    #1;
    check("disabled_led_out",   {24'd0, led_out},           32'hFF);
    check("disabled_presc_cnt", {16'd0, dut.presc_cnt_q},   32'h0);
    check("disabled_pwm_cnt",   {24'd0, dut.pwm_cnt_q},     32'h0);
    check("disabled_blink_cnt", {24'd0, dut.blink_cnt_q},   32'h0);
    check("disabled_phase",     {31'd0, dut.blink_phase_q}, 32'h1);

    // PRESCALE=3: tick every 4 clocks, frame of 1024 clocks
    do_reset();
    led_in = 8'hFF;
    bus_write(2'd1, 32'd3);
    bus_write(2'd0, 32'h1);
    bad = 0;
    for (int k = 0; k < 1103; k++) begin
      @(posedge clk); #1;
      expv = (((k / 4) % 256) == 255) ? 8'h00 : 8'hFF;
      if (led_out !== expv) bad++;
    end
    check("presc3_bad_cycles", bad, 0);
    // Now in cycle 1103: presc_cnt==3, pwm_cnt==275 mod 256
    check("presc3_cnt_before", {16'd0, dut.presc_cnt_q}, 32'd3);
    check("presc3_pwm_before", {24'd0, dut.pwm_cnt_q},   32'd19);
    bus_write(2'd1, 32'd3);
    check("presc_clear_cnt_after", {16'd0, dut.presc_cnt_q}, 32'd0);
    check("presc_clear_no_tick",   {24'd0, dut.pwm_cnt_q},   32'd19);

    // Mid-frame reset pulse
    do_reset();
    led_in = 8'hFF;
    bus_write(2'd1, 32'd0);
    bus_write(2'd0, 32'h1);
    repeat (100) @(posedge clk);
    #1;
    check("pre_reset_led_out", {24'd0, led_out}, 32'hFF);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("async_reset_led_out", {24'd0, led_out}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    read_chk("post_reset_ctrl",     2'd0, 32'h0);
    read_chk("post_reset_prescale", 2'd1, 32'h31);
    check("post_reset_pwm_cnt", {24'd0, dut.pwm_cnt_q}, 32'h0);
    repeat (4) @(posedge clk);
    #1;
    check("post_reset_led_out", {24'd0, led_out}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
